// File: rtl/irq_priority_controller.sv
// Registered 8-input interrupt front-end: synchronise, latch pending, mask,
// resolve the highest unmasked index and run a single irq/ack/eoi handshake.
module irq_priority_controller #(
    parameter int unsigned N_SYNC     = 2,
    parameter bit          EDGE_MODE  = 1'b1,
    parameter logic [7:0]  RESET_MASK = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       mask_wr,
    input  logic [7:0] mask_in,
    input  logic       ack,
    input  logic       eoi,
    output logic       irq,
    output logic [2:0] vector,
    output logic [7:0] pending,
    output logic [7:0] in_service,
    output logic [7:0] mask
);

    typedef enum logic [1:0] {
        IDLE,
        ASSERT,
        SERVICE
    } state_t;

    logic [N_SYNC-1:0][7:0] sync_q;
    logic [7:0]             s_prev_q;
    logic [7:0]             s;
    logic [7:0]             set_vec;
    logic [7:0]             clr_vec;
    logic [7:0]             pending_q;
    logic [7:0]             mask_q;
    logic [7:0]             eligible;
    logic [2:0]             winner;

    state_t     state_q, state_d;
    logic       irq_q, irq_d;
    logic [2:0] vector_q, vector_d;
    logic [7:0] in_service_q, in_service_d;

    assign s        = sync_q[N_SYNC-1];
    assign set_vec  = EDGE_MODE ? (s & ~s_prev_q) : s;
    assign eligible = pending_q & ~mask_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            s_prev_q  <= '0;
            pending_q <= '0;
            mask_q    <= RESET_MASK;
        end else begin
            sync_q    <= {sync_q[N_SYNC-2:0], req};
            s_prev_q  <= s;
            // A set arriving on the same edge as an ack-clear must survive.
            pending_q <= (pending_q & ~clr_vec) | set_vec;
            if (mask_wr) begin
                mask_q <= mask_in;
            end
        end
    end

    // Ascending scan: the last hit is the highest eligible index.
    always_comb begin
        winner = '0;
        for (int i = 0; i < 8; i++) begin
            if (eligible[i]) begin
                winner = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            irq_q        <= 1'b0;
            vector_q     <= '0;
            in_service_q <= '0;
        end else begin
            state_q      <= state_d;
            irq_q        <= irq_d;
            vector_q     <= vector_d;
            in_service_q <= in_service_d;
        end
    end

    // NOTE: every signal driven here gets a default first so no path infers a latch.
    always_comb begin
        state_d      = state_q;
        irq_d        = irq_q;
        vector_d     = vector_q;
        in_service_d = in_service_q;
        clr_vec      = '0;
        case (state_q)
            IDLE: begin
                irq_d = 1'b0;
                if (|eligible) begin
                    vector_d = winner;
                    irq_d    = 1'b1;
                    state_d  = ASSERT;
                end
            end
            ASSERT: begin
                // vector stays frozen here; later higher-priority arrivals wait.
                if (ack) begin
                    clr_vec      = 8'b1 << vector_q;
                    in_service_d = 8'b1 << vector_q;
                    irq_d        = 1'b0;
                    state_d      = SERVICE;
                end else if (!eligible[vector_q]) begin
                    irq_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                irq_d = 1'b0;
                if (eoi) begin
                    in_service_d = '0;
                    state_d      = IDLE;
                end
            end
            default: begin
                irq_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign irq        = irq_q;
    assign vector     = vector_q;
    assign pending    = pending_q;
    assign in_service = in_service_q;
    assign mask       = mask_q;

endmodule
